// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types for the data-memory responder: FSM state encoding, the
//   latched request record and the word size in bytes.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Load/store port between the core (master) and the data-memory
//   responder (slave).
//   req_valid/req_ready      request handshake
//   req_we/addr/wdata/be     request payload (be ignored for loads)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        response payload
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_sram_be.sv
// sram_be
//   DEPTH_WORDS x 32 single-port synchronous array with per-byte write
//   enables. On an enabled edge the addressed word is read into the output
//   register (old contents) and the enabled bytes are written.
//   clk       clock
//   i_en      access enable
//   i_we      write enable (qualified per byte by i_be)
//   i_be      byte enables, byte b is [8b+7:8b]
//   i_idx     word index
//   i_wdata   write data
//   o_rdata   registered read data, holds until the next enabled access
module sram_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) begin
            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data load/store port. Accepts one
//   request at a time, waits WAIT_CYCLES, performs a byte-enabled store or a
//   word load on an internal array, then presents the response until the
//   core takes it.
//   clk     clock
//   rst_n   synchronous active-low reset
//   bus     dmem_responder_if.slave (request and response handshakes)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | req_ready high, waiting for a request
//   WAIT  | request latched, counting down wait states; access at count 1
//   RESP  | rsp_valid high, rdata/err held until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT       = 33'(WORD_BYTES * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES);
  localparam dmem_state_t ACCEPT_NEXT = (WAIT_CYCLES == 0) ? RESP : WAIT;

  dmem_state_t      r_state;
  logic [3:0]       r_cnt;
  dmem_req_t        r_req;
  logic             r_rsp_load;
  logic             r_rsp_err;

  dmem_req_t        w_live;
  dmem_req_t        w_cur;
  logic             w_accept;
  logic             w_access;
  logic [32:0]      w_off;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_sram_rdata;

  assign w_live = '{we:    bus.req_we,
                    addr:  bus.req_addr,
                    wdata: bus.req_wdata,
                    be:    bus.req_be};

  assign w_accept = rst_n && (r_state == IDLE) && bus.req_valid;

  // With zero wait states the access happens on the acceptance edge, so the
  // live request feeds the array; otherwise the latched copy does.
  assign w_access = rst_n && ((w_accept && (WAIT_CYCLES == 0)) ||
                              ((r_state == WAIT) && (r_cnt == 4'd1)));
  assign w_cur    = (r_state == IDLE) ? w_live : r_req;

  // 33-bit offset: bit 32 set means the address lies below BASE_ADDR.
  assign w_off = {1'b0, w_cur.addr} - {1'b0, BASE_ADDR};
  assign w_err = (w_cur.addr[1:0] != 2'b00) || w_off[32] || (w_off >= LIMIT);
  assign w_idx = w_off[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rsp_load <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_req   <= w_live;
            r_cnt   <= WAIT_INIT;
            r_state <= ACCEPT_NEXT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd1) begin
            r_cnt   <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state    <= IDLE;
            r_rsp_load <= 1'b0;
            r_rsp_err  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_access) begin
        r_rsp_err  <= w_err;
        r_rsp_load <= !w_cur.we && !w_err;
      end
    end
  end

  sram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_access),
    .i_we    (w_cur.we && !w_err),
    .i_be    (w_cur.be),
    .i_idx   (w_idx),
    .i_wdata (w_cur.wdata),
    .o_rdata (w_sram_rdata)
  );

  // The array's read register is not reset; the load flag masks it so that
  // stores, errors and post-reset cycles all present zero.
  assign bus.req_ready = rst_n && (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rsp_load ? w_sram_rdata : 32'h0;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data load/store port. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It then performs a byte-enabled write or a word read on an internal word array, and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory, so the core can be exercised against realistic multi-cycle memory timing.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- WAIT_CYCLES, 2: wait states between acceptance and access; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte i is [8i+7:8i].
- req_be  in  4  store byte enables; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  access was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid && req_ready, latch we/addr/wdata/be and load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise RESP.
- WAIT
  - The counter decrements each cycle.
  - When it reaches 1, the access is performed at that edge and the next state is RESP.
- Access, performed once per transaction:
  - Error if addr[1:0] != 0, or if addr < BASE_ADDR, or if addr >= BASE_ADDR + 4*DEPTH_WORDS.
  - On error: no array write; rsp_rdata = 0; rsp_err = 1.
  - Store: each byte whose req_be bit is set is written at index (addr-BASE_ADDR)>>2; all other bytes are unchanged. be = 4'b0000 is a legal no-op store. rsp_rdata = 0.
  - Load: rsp_rdata = the full word at the index.
- RESP
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_ready, go to IDLE.
  - rsp_valid never drops without a handshake.
- Inputs are not sampled outside IDLE; req_* may change freely while req_ready = 0.
- Reset (rst_n low at an edge) from any state:
  - Next state is IDLE; counter cleared.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready is 0 while rst_n is low and 1 in the first cycle after release.
  - An in-flight transaction is dropped. If it was still in WAIT, its store never commits.
  - Array contents are not cleared by reset.

## Timing
- Acceptance in cycle N gives rsp_valid = 1 in cycle N + WAIT_CYCLES + 1.
- Handshake in cycle M (rsp_valid && rsp_ready) gives req_ready = 1 in cycle M+1.
- Minimum transaction period: WAIT_CYCLES + 2 cycles. There is no overlap; responses never pipeline with requests.
- A store completes before its response. A load accepted after a store response observes the stored bytes.
- The array is read and written synchronously at the access edge. There is no combinational path from req_* to rsp_*.
- rsp_ready held low stalls indefinitely in RESP without any state change.

## Structure
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  - the request struct (we, addr, wdata, be);
  - localparam WORD_BYTES = 4.
- Sub-module sram_be (DEPTH_WORDS x 32 array):
  - one synchronous port: en, we, be[3:0], idx, wdata, rdata;
  - per-byte write enables.
- The FSM, counter, range/alignment check and response registers live in dmem_responder.

## Test plan
- Round trip, W=2: store addr 0x10, data 0xDEADBEEF, be=4'hF; then load 0x10. Each response arrives 3 cycles after acceptance; the load returns 0xDEADBEEF with err=0.
- Byte enables: preload 0x11223344 at 0x20; store 0xAABBCCDD with be=4'b0101; load returns 0x11BB33DD.
- Errors: load 0x22 (misaligned) and load BASE_ADDR+4*DEPTH_WORDS (out of range) each give err=1, rdata=0. A store to 0x22 leaves word 0x20 unchanged.
- Back-pressure, W=0: hold rsp_ready=0 for 5 cycles. rsp_valid and rdata stay stable; req_ready stays 0 throughout; req_ready rises the cycle after rsp_ready rises.
- Reset mid-WAIT (W=4): assert rst_n=0 two cycles after a store to 0x30 is accepted. rsp_valid stays 0, req_ready=1 after release, and a load of 0x30 returns the prior contents.
